// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the SRAM access arbiter.
package sram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TURN   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Requester and SRAM pin bundle; master = arbiter side, slave = requesters/SRAM side.
interface sram_access_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              req0;
  logic              req1;
  logic              wen0;
  logic              wen1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              sram_read_enable;
  logic              sram_write_enable;
  logic [ADDR_W-1:0] sram_address;
  logic [DATA_W-1:0] sram_write_data;
  logic [DATA_W-1:0] sram_read_data;

  modport master (
    input  req0, req1, wen0, wen1, addr0, addr1, wdata0, wdata1, sram_read_data,
    output ack0, ack1, rdata, busy,
    output sram_read_enable, sram_write_enable, sram_address, sram_write_data
  );

  modport slave (
    output req0, req1, wen0, wen1, addr0, addr1, wdata0, wdata1, sram_read_data,
    input  ack0, ack1, rdata, busy,
    input  sram_read_enable, sram_write_enable, sram_address, sram_write_data
  );

endinterface

// File: rtl/sram_access_arbiter_rr_arbiter2.sv
// Two-input round-robin grant: on a tie the port that did not win last time is chosen.
module rr_arbiter2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic grant_valid_c_o,
  output logic grant_id_c_o
);

  assign grant_valid_c_o = req0_i | req1_i;
  assign grant_id_c_o    = (req0_i & req1_i) ? ~last_grant_i : req1_i;

endmodule

// File: rtl/sram_access_arbiter.sv
// Round-robin sequencer for a single-port SRAM shared by two requesters.
// Optional SRAM_TURNAROUND_EN inserts a dead cycle when the access direction flips.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = ADDR_W_DEF,
  parameter int unsigned DATA_W        = DATA_W_DEF,
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  sram_access_arbiter_if.master bus
);

  localparam int unsigned CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              gid_q, gid_d;
  logic              wen_q, wen_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              busy_q, busy_d;
`ifdef SRAM_TURNAROUND_EN
  logic              lww_q, lww_d;
`endif

  logic              grant_valid_c;
  logic              grant_id_c;
  logic              sel_wen_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;

  rr_arbiter2 u_rr_arbiter2 (
    .req0_i          (bus.req0),
    .req1_i          (bus.req1),
    .last_grant_i    (last_grant_q),
    .grant_valid_c_o (grant_valid_c),
    .grant_id_c_o    (grant_id_c)
  );

  assign sel_wen_c   = grant_id_c ? bus.wen1   : bus.wen0;
  assign sel_addr_c  = grant_id_c ? bus.addr1  : bus.addr0;
  assign sel_wdata_c = grant_id_c ? bus.wdata1 : bus.wdata0;

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      gid_q        <= 1'b0;
      wen_q        <= 1'b0;
      re_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SRAM_TURNAROUND_EN
      lww_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      gid_q        <= gid_d;
      wen_q        <= wen_d;
      re_q         <= re_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      busy_q       <= busy_d;
`ifdef SRAM_TURNAROUND_EN
      lww_q        <= lww_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    gid_d        = gid_q;
    wen_d        = wen_q;
    re_d         = re_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
`ifdef SRAM_TURNAROUND_EN
    lww_d        = lww_q;
`endif

    case (state_q)
      IDLE: begin
        if (grant_valid_c) begin
          gid_d        = grant_id_c;
          last_grant_d = grant_id_c;
          wen_d        = sel_wen_c;
          addr_d       = sel_addr_c;
          wdata_d      = sel_wdata_c;
          cnt_d        = '0;
`ifdef SRAM_TURNAROUND_EN
          lww_d = sel_wen_c;
          // Direction flip: park one cycle with enables low before driving the bus.
          if (sel_wen_c != lww_q) begin
            state_d = TURN;
          end else begin
            state_d = ACCESS;
            we_d    = sel_wen_c;
            re_d    = ~sel_wen_c;
          end
`else
          state_d = ACCESS;
          we_d    = sel_wen_c;
          re_d    = ~sel_wen_c;
`endif
        end
      end
      TURN: begin
        state_d = ACCESS;
        we_d    = wen_q;
        re_d    = ~wen_q;
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          re_d    = 1'b0;
          we_d    = 1'b0;
          state_d = DONE;
          ack0_d  = ~gid_q;
          ack1_d  = gid_q;
          if (!wen_q) begin
            rdata_d = bus.sram_read_data;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        re_d    = 1'b0;
        we_d    = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.sram_read_enable  = re_q;
  assign bus.sram_write_enable = we_q;
  assign bus.sram_address      = addr_q;
  assign bus.sram_write_data   = wdata_q;
  assign bus.rdata             = rdata_q;
  assign bus.ack0              = ack0_q;
  assign bus.ack1              = ack1_q;
  assign bus.busy              = busy_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed scoreboard bench for sram_access_arbiter (ACCESS_CYCLES 1 and 3 instances).
module tb_sram_access_arbiter;

`ifdef SRAM_TURNAROUND_EN
  localparam int TURN_EN = 1;
`else
  localparam int TURN_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic rst3_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sram_access_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();
  sram_access_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus3 ();

  sram_access_arbiter #(.ADDR_W(16), .DATA_W(8), .ACCESS_CYCLES(1)) dut (
    .clk(clk), .n_rst(rst_n), .bus(bus)
  );
  sram_access_arbiter #(.ADDR_W(16), .DATA_W(8), .ACCESS_CYCLES(3)) dut3 (
    .clk(clk), .n_rst(rst3_n), .bus(bus3)
  );

  // SRAM models: asynchronous read, write on the clock edge while enabled.
  logic [7:0] mem  [0:65535];
  logic [7:0] mem3 [0:65535];
  assign bus.sram_read_data  = mem[bus.sram_address];
  assign bus3.sram_read_data = mem3[bus3.sram_address];
  always @(posedge clk) if (bus.sram_write_enable)  mem[bus.sram_address]   <= bus.sram_write_data;
  always @(posedge clk) if (bus3.sram_write_enable) mem3[bus3.sram_address] <= bus3.sram_write_data;

  typedef struct {
    bit         port;
    bit         wen;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          ack_at;
  } item_t;

  item_t      sb[$];
  logic [7:0] ref_mem [int];
  bit         m_lww;
  logic [7:0] m_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Queue the expected outcome; start = cycles after the first sampling edge. Returns start of next.
  function automatic int push(input bit port, input bit wen, input logic [15:0] addr,
                              input logic [7:0] wdata, input int start);
    item_t it;
    int    turn;
    turn = 0;
    if (TURN_EN != 0 && wen != m_lww) turn = 1;
    m_lww     = wen;
    it.port   = port;
    it.wen    = wen;
    it.addr   = addr;
    it.wdata  = wdata;
    it.ack_at = start + turn + 2;
    if (wen) begin
      ref_mem[int'(addr)] = wdata;
      it.rdata = m_rdata;
    end else begin
      it.rdata = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 8'h00;
      m_rdata  = it.rdata;
    end
    sb.push_back(it);
    return start + turn + 3;
  endfunction

  task automatic drive(input bit port, input bit wen, input logic [15:0] addr, input logic [7:0] wdata);
    if (!port) begin
      bus.req0 = 1'b1; bus.wen0 = wen; bus.addr0 = addr; bus.wdata0 = wdata;
    end else begin
      bus.req1 = 1'b1; bus.wen1 = wen; bus.addr1 = addr; bus.wdata1 = wdata;
    end
  endtask

  // Watch the ACCESS_CYCLES=1 instance until the scoreboard drains or the budget expires.
  task automatic run(input int budget);
    int    cyc;
    int    en;
    item_t it;
    cyc = 0;
    en  = 0;
    while (sb.size() != 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      chk("excl_en", 32'(bus.sram_read_enable & bus.sram_write_enable), 32'd0);
      if (bus.sram_read_enable || bus.sram_write_enable) begin
        en++;
        chk("en_addr", 32'(bus.sram_address), 32'(sb[0].addr));
        chk("en_dir", 32'(bus.sram_write_enable), 32'(sb[0].wen));
        if (sb[0].wen) chk("en_wdata", 32'(bus.sram_write_data), 32'(sb[0].wdata));
      end
      if (bus.ack0 || bus.ack1) begin
        it = sb.pop_front();
        chk("ack_port", 32'({bus.ack1, bus.ack0}), it.port ? 32'd2 : 32'd1);
        chk("ack_lat", 32'(cyc), 32'(it.ack_at));
        chk("en_cycles", 32'(en), 32'd1);
        chk("rdata", 32'(bus.rdata), 32'(it.rdata));
        chk("busy_done", 32'(bus.busy), 32'd1);
        en = 0;
        if (it.port) bus.req1 = 1'b0;
        else         bus.req0 = 1'b0;
      end
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  // One access on the ACCESS_CYCLES=3 instance.
  task automatic acc3(input bit port, input bit wen, input logic [15:0] addr, input logic [7:0] wdata,
                      input int exp_ack, input logic [7:0] exp_rdata);
    int cyc;
    int en;
    bit got;
    cyc = 0;
    en  = 0;
    got = 1'b0;
    if (!port) begin
      bus3.req0 = 1'b1; bus3.wen0 = wen; bus3.addr0 = addr; bus3.wdata0 = wdata;
    end else begin
      bus3.req1 = 1'b1; bus3.wen1 = wen; bus3.addr1 = addr; bus3.wdata1 = wdata;
    end
    while (!got && cyc < 30) begin
      @(negedge clk);
      cyc++;
      chk("d3_excl", 32'(bus3.sram_read_enable & bus3.sram_write_enable), 32'd0);
      if (wen ? bus3.sram_write_enable : bus3.sram_read_enable) begin
        en++;
        chk("d3_addr", 32'(bus3.sram_address), 32'(addr));
      end
      if (bus3.ack0 || bus3.ack1) begin
        got = 1'b1;
        chk("d3_ack_port", 32'({bus3.ack1, bus3.ack0}), port ? 32'd2 : 32'd1);
        chk("d3_ack_lat", 32'(cyc), 32'(exp_ack));
        chk("d3_en_cycles", 32'(en), 32'd3);
        chk("d3_rdata", 32'(bus3.rdata), 32'(exp_rdata));
        bus3.req0 = 1'b0;
        bus3.req1 = 1'b0;
      end
    end
    chk("d3_ack_seen", 32'(got), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int d;
    int w;
    for (int i = 0; i < 65536; i++) begin
      mem[i]  = 8'h00;
      mem3[i] = 8'h00;
    end
    bus.req0 = 0; bus.req1 = 0; bus.wen0 = 0; bus.wen1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus3.req0 = 0; bus3.req1 = 0; bus3.wen0 = 0; bus3.wen1 = 0;
    bus3.addr0 = '0; bus3.addr1 = '0; bus3.wdata0 = '0; bus3.wdata1 = '0;
    m_lww   = 1'b0;
    m_rdata = 8'h00;
    rst_n   = 1'b0;
    rst3_n  = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_re", 32'(bus.sram_read_enable), 32'd0);
    chk("rst_we", 32'(bus.sram_write_enable), 32'd0);
    chk("rst_ack", 32'({bus.ack1, bus.ack0}), 32'd0);
    chk("rst_addr", 32'(bus.sram_address), 32'd0);
    chk("rst_wdata", 32'(bus.sram_write_data), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    rst_n  = 1'b1;
    rst3_n = 1'b1;
    @(negedge clk);

    // Single write, then read back from the other port.
    drive(0, 1, 16'h0008, 8'h05); void'(push(0, 1, 16'h0008, 8'h05, 0)); run(20);
    drive(1, 0, 16'h0008, 8'h00); void'(push(1, 0, 16'h0008, 8'h00, 0)); run(20);

    // Tie with last_grant=1: port 0 first.
    drive(0, 1, 16'h0020, 8'h3C); drive(1, 0, 16'h0008, 8'h00);
    d = push(0, 1, 16'h0020, 8'h3C, 0); void'(push(1, 0, 16'h0008, 8'h00, d)); run(30);

    // Single port-0 access leaves last_grant=0, so the next tie goes to port 1.
    drive(0, 0, 16'h0020, 8'h00); void'(push(0, 0, 16'h0020, 8'h00, 0)); run(20);
    drive(0, 1, 16'h0030, 8'h77); drive(1, 1, 16'h0040, 8'h88);
    d = push(1, 1, 16'h0040, 8'h88, 0); void'(push(0, 1, 16'h0030, 8'h77, d)); run(30);
    drive(1, 0, 16'h0030, 8'h00); void'(push(1, 0, 16'h0030, 8'h00, 0)); run(20);

    // Reset in the middle of a write access.
    drive(0, 1, 16'h0010, 8'h99);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.sram_write_enable && w < 5);
    chk("midrst_we_seen", 32'(bus.sram_write_enable), 32'd1);
    #1 rst_n = 1'b0;
    bus.req0 = 1'b0;
    #1;
    chk("midrst_we", 32'(bus.sram_write_enable), 32'd0);
    chk("midrst_re", 32'(bus.sram_read_enable), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_rdata", 32'(bus.rdata), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_ack", 32'({bus.ack1, bus.ack0}), 32'd0);
    end
    rst_n   = 1'b1;
    m_lww   = 1'b0;
    m_rdata = 8'h00;
    @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_rdata", 32'(bus.rdata), 32'd0);

    // After reset the tie goes to port 0 again; the abandoned write never reached memory.
    drive(0, 0, 16'h0010, 8'h00); drive(1, 0, 16'h0008, 8'h00);
    d = push(0, 0, 16'h0010, 8'h00, 0); void'(push(1, 0, 16'h0008, 8'h00, d)); run(30);

    // Three-cycle accesses at the top of the address space.
    acc3(0, 1, 16'hFFFF, 8'h5A, 4 + TURN_EN, 8'h00);
    acc3(1, 0, 16'hFFFF, 8'h00, 4 + TURN_EN, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
